mcb_port_bram: RTL and testbench

//  BRAM-backed responder for one 32-bit MCB-style user port (cmd / wr / rd FIFO interfaces).

---
 rtl/mcb_port_pkg.sv | 41 ++++
 rtl/mcb_port_bram_fifo.sv | 66 ++++++
 rtl/mcb_port_bram.sv | 161 ++++++++++++++++
 tb/tb_mcb_port_bram.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mcb_port_pkg.sv
// Shared types and constants for the BRAM-backed MCB user-port responder.
package mcb_port_pkg;

  localparam logic [2:0] INSTR_WR    = 3'b000;
  localparam logic [2:0] INSTR_RD    = 3'b001;
  localparam logic [2:0] INSTR_WR_AP = 3'b010;
  localparam logic [2:0] INSTR_RD_AP = 3'b011;

  typedef enum logic [2:0] {
    CALIB,
    IDLE,
    WR_XFER,
    RD_XFER,
    RD_FLUSH
  } state_e;

  localparam int unsigned ERR_CMD_OVF      = 0;
  localparam int unsigned ERR_WR_OVF       = 1;
  localparam int unsigned ERR_WR_UNDERRUN  = 2;
  localparam int unsigned ERR_RD_UNDERFLOW = 3;

  typedef struct packed {
    logic [2:0]  instr;
    logic [5:0]  bl;
    logic [29:0] byte_addr;
  } cmd_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  mask;
  } wr_word_t;

  function automatic logic is_read(input logic [2:0] instr);
    return (instr == INSTR_RD) || (instr == INSTR_RD_AP);
  endfunction

  function automatic logic is_write(input logic [2:0] instr);
    return (instr == INSTR_WR) || (instr == INSTR_WR_AP);
  endfunction

endpackage

// File: rtl/mcb_port_bram_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count; head reads 0 while empty.
module sync_fifo_fwft #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     reset_d,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == (AW+1)'(DEPTH));
  assign count     = count_q;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts a push alongside it.
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign overflow  = push && !do_push;
  assign underflow = pop && empty;
  assign pop_data  = empty ? '0 : mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset_d) begin
    if (reset_d) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/mcb_port_bram.sv
// BRAM-backed responder for one 32-bit MCB-style user port: cmd/wr/rd FIFOs in front of
// an inferred 1-cycle BRAM, serviced one command at a time in strict FIFO order.
module mcb_port_bram
  import mcb_port_pkg::*;
#(
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned FIFO_DEPTH   = 64,
  parameter int unsigned CMD_DEPTH    = 4,
  parameter int unsigned CALIB_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          reset_d,
  output logic                          calib_done,
  input  logic                          cmd_en,
  input  logic [2:0]                    cmd_instr,
  input  logic [5:0]                    cmd_bl,
  input  logic [29:0]                   cmd_byte_addr,
  output logic                          cmd_full,
  output logic                          cmd_empty,
  input  logic                          wr_en,
  input  logic [31:0]                   wr_data,
  input  logic [3:0]                    wr_mask,
  output logic                          wr_full,
  output logic                          wr_empty,
  output logic [$clog2(FIFO_DEPTH):0]   wr_count,
  input  logic                          rd_en,
  output logic [31:0]                   rd_data,
  output logic                          rd_full,
  output logic                          rd_empty,
  output logic [$clog2(FIFO_DEPTH):0]   rd_count,
  output logic [3:0]                    err
);

  localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned CAL_W = $clog2(CALIB_CYCLES) + 1;
  localparam logic [CW:0] RD_LIMIT = (CW+1)'(FIFO_DEPTH);

  cmd_t     cmd_in, cmd_head;
  wr_word_t wr_in, wr_head;
  logic     cmd_pop, wr_pop;
  logic     cmd_ovf, wr_ovf, rd_unf;
  logic     cmd_unf_unused, wr_unf_unused, rd_ovf_unused, unused_addr_bits;
  logic [$clog2(CMD_DEPTH):0] cmd_count_unused;

  state_e             state_q, state_d;
  logic [CAL_W-1:0]   calib_cnt_q, calib_cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [6:0]         rem_q, rem_d;
  logic [3:0]         err_q, err_d;
  logic               rd_valid_q, rd_valid_d;
  logic               bram_we, bram_re;
  logic [31:0]        bram [2**ADDR_W];
  logic [31:0]        bram_rdata_q;

  assign cmd_in = '{instr: cmd_instr, bl: cmd_bl, byte_addr: cmd_byte_addr};
  assign wr_in  = '{data: wr_data, mask: wr_mask};
  assign unused_addr_bits = ^{cmd_head.byte_addr[29:ADDR_W+2], cmd_head.byte_addr[1:0]};

  sync_fifo_fwft #(.WIDTH($bits(cmd_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk(clk), .reset_d(reset_d), .push(cmd_en), .push_data(cmd_in), .pop(cmd_pop),
    .pop_data(cmd_head), .full(cmd_full), .empty(cmd_empty), .count(cmd_count_unused),
    .overflow(cmd_ovf), .underflow(cmd_unf_unused)
  );

  sync_fifo_fwft #(.WIDTH($bits(wr_word_t)), .DEPTH(FIFO_DEPTH)) u_wr_fifo (
    .clk(clk), .reset_d(reset_d), .push(wr_en), .push_data(wr_in), .pop(wr_pop),
    .pop_data(wr_head), .full(wr_full), .empty(wr_empty), .count(wr_count),
    .overflow(wr_ovf), .underflow(wr_unf_unused)
  );

  sync_fifo_fwft #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_rd_fifo (
    .clk(clk), .reset_d(reset_d), .push(rd_valid_q), .push_data(bram_rdata_q), .pop(rd_en),
    .pop_data(rd_data), .full(rd_full), .empty(rd_empty), .count(rd_count),
    .overflow(rd_ovf_unused), .underflow(rd_unf)
  );

  assign calib_done = (state_q != CALIB);
  assign err        = err_q;

  always_comb begin
    state_d     = state_q;
    calib_cnt_d = calib_cnt_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    err_d       = err_q;
    cmd_pop     = 1'b0;
    wr_pop      = 1'b0;
    bram_we     = 1'b0;
    bram_re     = 1'b0;
    err_d[ERR_CMD_OVF]      = err_q[ERR_CMD_OVF] | cmd_ovf;
    err_d[ERR_WR_OVF]       = err_q[ERR_WR_OVF] | wr_ovf;
    err_d[ERR_RD_UNDERFLOW] = err_q[ERR_RD_UNDERFLOW] | rd_unf;
    unique case (state_q)
      CALIB: begin
        if (calib_cnt_q == CAL_W'(CALIB_CYCLES - 1)) state_d = IDLE;
        else calib_cnt_d = calib_cnt_q + 1'b1;
      end
      IDLE: begin
        if (!cmd_empty) begin
          cmd_pop = 1'b1;
          addr_d  = cmd_head.byte_addr[ADDR_W+1:2];
          rem_d   = 7'(cmd_head.bl) + 7'd1;
          if (is_read(cmd_head.instr))       state_d = RD_XFER;
          else if (is_write(cmd_head.instr)) state_d = WR_XFER;
          else                               state_d = IDLE;
        end
      end
      WR_XFER: begin
        if (wr_empty) begin
          err_d[ERR_WR_UNDERRUN] = 1'b1;
        end else begin
          wr_pop  = 1'b1;
          bram_we = 1'b1;
          addr_d  = addr_q + 1'b1;
          rem_d   = rem_q - 7'd1;
          if (rem_q == 7'd1) state_d = IDLE;
        end
      end
      RD_XFER: begin
        // Reserve a rd FIFO slot for the word still in the BRAM output register.
        if (({1'b0, rd_count} + (CW+1)'(rd_valid_q)) < RD_LIMIT) begin
          bram_re = 1'b1;
          addr_d  = addr_q + 1'b1;
          rem_d   = rem_q - 7'd1;
          if (rem_q == 7'd1) state_d = RD_FLUSH;
        end
      end
      RD_FLUSH: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    rd_valid_d = bram_re;
  end

  always_ff @(posedge clk or posedge reset_d) begin
    if (reset_d) begin
      state_q     <= CALIB;
      calib_cnt_q <= '0;
      addr_q      <= '0;
      rem_q       <= '0;
      err_q       <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      calib_cnt_q <= calib_cnt_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      err_q       <= err_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  // Mask bit set means the byte is preserved.
  always_ff @(posedge clk) begin
    if (bram_we && !wr_head.mask[0]) bram[addr_q][7:0]   <= wr_head.data[7:0];
    if (bram_we && !wr_head.mask[1]) bram[addr_q][15:8]  <= wr_head.data[15:8];
    if (bram_we && !wr_head.mask[2]) bram[addr_q][23:16] <= wr_head.data[23:16];
    if (bram_we && !wr_head.mask[3]) bram[addr_q][31:24] <= wr_head.data[31:24];
    if (bram_re) bram_rdata_q <= bram[addr_q];
  end

endmodule

// File: tb/tb_mcb_port_bram.sv
// Directed self-checking bench for mcb_port_bram with hand-computed expectations.
module tb_mcb_port_bram;
  import mcb_port_pkg::*;

  logic        clk = 1'b0;
  logic        reset_d;
  logic        calib_done;
  logic        cmd_en;
  logic [2:0]  cmd_instr;
  logic [5:0]  cmd_bl;
  logic [29:0] cmd_byte_addr;
  logic        cmd_full, cmd_empty;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [3:0]  wr_mask;
  logic        wr_full, wr_empty;
  logic [6:0]  wr_count;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        rd_full, rd_empty;
  logic [6:0]  rd_count;
  logic [3:0]  err;

  int n_checks = 0;
  int n_fail   = 0;

  mcb_port_bram #(
    .ADDR_W(10), .FIFO_DEPTH(64), .CMD_DEPTH(4), .CALIB_CYCLES(16)
  ) dut (
    .clk(clk), .reset_d(reset_d), .calib_done(calib_done),
    .cmd_en(cmd_en), .cmd_instr(cmd_instr), .cmd_bl(cmd_bl), .cmd_byte_addr(cmd_byte_addr),
    .cmd_full(cmd_full), .cmd_empty(cmd_empty),
    .wr_en(wr_en), .wr_data(wr_data), .wr_mask(wr_mask),
    .wr_full(wr_full), .wr_empty(wr_empty), .wr_count(wr_count),
    .rd_en(rd_en), .rd_data(rd_data), .rd_full(rd_full), .rd_empty(rd_empty),
    .rd_count(rd_count), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input logic [31:0] d, input logic [3:0] m);
    wr_data = d;
    wr_mask = m;
    wr_en   = 1'b1;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic push_cmd(input logic [2:0] ins, input logic [5:0] bl, input logic [29:0] a);
    cmd_instr     = ins;
    cmd_bl        = bl;
    cmd_byte_addr = a;
    cmd_en        = 1'b1;
    tick();
    cmd_en        = 1'b0;
  endtask

  task automatic wait_drained(input string tag);
    for (int i = 0; i < 300 && !(wr_empty && cmd_empty); i++) tick();
    tick();
    tick();
    check(tag, {30'd0, wr_empty, cmd_empty}, 32'd3);
  endtask

  task automatic pop_check(input string tag, input logic [31:0] exp);
    for (int i = 0; i < 300 && rd_empty; i++) tick();
    check(tag, rd_data, exp);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic check_reset_status(input string p);
    check({p, "_calib"},   calib_done, 0);
    check({p, "_cmd_fl"},  {cmd_full, cmd_empty}, 32'b01);
    check({p, "_wr_fl"},   {wr_full, wr_empty}, 32'b01);
    check({p, "_rd_fl"},   {rd_full, rd_empty}, 32'b01);
    check({p, "_wr_cnt"},  wr_count, 0);
    check({p, "_rd_cnt"},  rd_count, 0);
    check({p, "_rd_data"}, rd_data, 0);
    check({p, "_err"},     err, 0);
  endtask

  // Counts the calibration window edge by edge, optionally pushing read commands meanwhile.
  task automatic check_calib(input int n_cmds);
    cmd_instr     = INSTR_RD;
    cmd_bl        = 6'd0;
    cmd_byte_addr = 30'h40;
    for (int i = 1; i <= 16; i++) begin
      cmd_en = (i <= n_cmds);
      tick();
      check("calib_window", calib_done, (i == 16));
    end
    cmd_en = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_d = 1'b1;
    cmd_en = 0; cmd_instr = 0; cmd_bl = 0; cmd_byte_addr = 0;
    wr_en = 0; wr_data = 0; wr_mask = 0; rd_en = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_status("rst");
    reset_d = 1'b0;
    check_calib(0);

    // 32-word burst write then read-back with latency and streaming checks
    for (int i = 0; i < 32; i++) push_wr(32'hA000_0000 + i, 4'b0000);
    check("wr_count32", wr_count, 32);
    push_cmd(INSTR_WR, 6'd31, 30'h40);
    wait_drained("burst_wr_done");
    cmd_instr = INSTR_RD; cmd_bl = 6'd31; cmd_byte_addr = 30'h40; cmd_en = 1'b1;
    tick();
    cmd_en = 1'b0;
    check("lat_e0", rd_empty, 1);
    tick();
    check("lat_e1", rd_empty, 1);
    tick();
    check("lat_e2", rd_empty, 1);
    tick();
    check("lat_e3", rd_empty, 0);
    for (int i = 0; i < 32; i++) begin
      check("burst_rd", rd_data, 32'hA000_0000 + i);
      rd_en = 1'b1;
      tick();
    end
    rd_en = 1'b0;
    check("burst_rd_empty", rd_empty, 1);

    // Byte mask, with read queued right behind the write
    push_wr(32'hFFFF_FFFF, 4'b0000);
    push_cmd(INSTR_WR, 6'd0, 30'h14);
    wait_drained("mask_wr1");
    push_wr(32'h1234_5678, 4'b0101);
    push_cmd(INSTR_WR_AP, 6'd0, 30'h14);
    push_cmd(INSTR_RD_AP, 6'd0, 30'h14);
    pop_check("mask_data", 32'h12FF_56FF);
    check("mask_err", err, 0);

    // Refresh is consumed without producing data
    push_cmd(3'b100, 6'd5, 30'h0);
    repeat (6) tick();
    check("refresh_nop", {30'd0, cmd_empty, rd_empty}, 32'd3);

    // Address wrap within a burst; byte offset and upper address bits ignored on read
    for (int i = 1; i <= 4; i++) push_wr(i, 4'b0000);
    push_cmd(INSTR_WR, 6'd3, 30'hFF8);
    wait_drained("wrap_wr");
    push_cmd(INSTR_RD, 6'd1, 30'h0);
    pop_check("wrap_w0", 32'd3);
    pop_check("wrap_w1", 32'd4);
    push_cmd(INSTR_RD, 6'd3, 30'h1FFB);
    for (int i = 1; i <= 4; i++) pop_check("wrap_rd_across", i);

    // Full 64-word write (plus one dropped overflow word), then back-pressured 64-word read
    for (int i = 0; i < 64; i++) push_wr(32'hB000_0000 + i, 4'b0000);
    check("wr_full", wr_full, 1);
    push_wr(32'hDEAD_BEEF, 4'b0000);
    check("wr_ovf_err", err, 4'b0010);
    check("wr_ovf_count", wr_count, 64);
    push_cmd(INSTR_WR, 6'd63, 30'h400);
    wait_drained("bl63_wr");
    push_cmd(INSTR_RD, 6'd63, 30'h400);
    repeat (100) tick();
    check("rd_count_peak", rd_count, 64);
    check("rd_full", rd_full, 1);
    for (int i = 0; i < 64; i++) begin
      check("bl63_rd", rd_data, 32'hB000_0000 + i);
      rd_en = 1'b1;
      tick();
    end
    rd_en = 1'b0;
    check("bl63_empty", {rd_empty, rd_count}, {1'b1, 7'd0});

    // Write underrun: 10 of 32 words present, stall, then complete
    for (int i = 0; i < 10; i++) push_wr(32'hC000_0000 + i, 4'b0000);
    push_cmd(INSTR_WR, 6'd31, 30'h800);
    repeat (20) tick();
    check("underrun_err", err, 4'b0110);
    check("underrun_stall", {30'd0, wr_empty, cmd_empty}, 32'd3);
    for (int i = 10; i < 32; i++) push_wr(32'hC000_0000 + i, 4'b0000);
    wait_drained("underrun_done");
    push_cmd(INSTR_RD, 6'd31, 30'h800);
    for (int i = 0; i < 32; i++) pop_check("underrun_rd", 32'hC000_0000 + i);

    // rd_en while empty
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("rd_unf_err", err, 4'b1110);

    // Reset in the middle of a read burst
    push_cmd(INSTR_RD, 6'd63, 30'h400);
    for (int i = 0; i < 300 && rd_count < 5; i++) tick();
    check("midburst_started", (rd_count >= 5), 1);
    reset_d = 1'b1;
    #2;
    check_reset_status("rst2");
    tick();
    check_reset_status("rst2_hold");
    reset_d = 1'b0;
    check_calib(5);
    check("cmd_full_calib", cmd_full, 1);
    check("cmd_ovf_err", err, 4'b0001);
    for (int i = 0; i < 4; i++) pop_check("queued_rd", 32'hA000_0000);
    push_cmd(INSTR_RD, 6'd3, 30'h400);
    for (int i = 0; i < 4; i++) pop_check("post_reset_rd", 32'hB000_0000 + i);
    repeat (4) tick();
    check("final_idle", {29'd0, cmd_empty, wr_empty, rd_empty}, 32'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
